// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption datapath: one full round per clock on a 128-bit state.
// Latency: accept on edge T, rounds on edges T+1..T+Nr, out_valid after edge T+Nr.
// Backpressure: no input buffering; in_ready only in IDLE; DONE holds until out_ready.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   in_valid/in_ready  plaintext handshake (in_ready = FSM in IDLE)
//   plaintext          128-bit block, byte 0 at [127:120]
//   W                  flattened round-key bus, word k at W[32*(k+1)-1 -: 32]
//   out_valid/out_ready ciphertext handshake
//   ciphertext         128-bit block, byte 0 at [127:120]
//   busy               high whenever the FSM is not IDLE
//
// Optional build macro AES_CIPHER_KEY_LATCH_EN: W is captured on input
// acceptance and every round reads the latched copy, so upstream may load a
// new key immediately after the handshake. Without it, rounds read W live.

// AES forward S-box, one byte in, one byte out.
// Latency: combinational.
// Backpressure: none (pure function).
module SubByte (
  input  logic [7:0] x,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  logic [10:0] idx;
  assign idx = 11'd2047 - {x, 3'b000};
  assign y   = SBOX[idx -: 8];
endmodule

// Iterative AES cipher core (AES-128/192/256 by KeySize).
// Latency: Nr+1 edges from accept to out_valid; one block per Nr+2 cycles.
// Backpressure: stalls in DONE with stable ciphertext while out_ready is low.
module aes_cipher_iter #(
  parameter  int KeySize = 128,
  localparam int Nr      = KeySize / 32 + 6,
  localparam int RK_W    = 128 * (Nr + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [127:0]      plaintext,
  input  logic [RK_W-1:0]   W,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [127:0]      ciphertext,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } fsm_t;

  fsm_t         fsm;
  fsm_t         fsm_nxt;
  logic [127:0] state;
  logic [3:0]   rnd;
  logic         last_rnd;
  logic [3:0]   rsel;
  logic [RK_W-1:0] key_bus;
  logic [127:0] rk;
  logic [127:0] sb;
  logic [127:0] sr;
  logic [127:0] mc;
  logic [127:0] rnd_out;

  assign last_rnd = (rnd == 4'(Nr));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (reset) fsm <= IDLE;
    else       fsm <= fsm_nxt;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (in_valid)  fsm_nxt = ROUND;
      ROUND:   if (last_rnd)  fsm_nxt = DONE;
      DONE:    if (out_ready) fsm_nxt = IDLE;
      default:                fsm_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    in_ready  = (fsm == IDLE);
    busy      = (fsm != IDLE);
    out_valid = (fsm == DONE);
  end

  assign ciphertext = state;

  // ---------------- Round-key source ----------------
`ifdef AES_CIPHER_KEY_LATCH_EN
  logic [RK_W-1:0] w_lat;

  always_ff @(posedge clk) begin
    if (reset)                        w_lat <= '0;
    else if (fsm == IDLE && in_valid) w_lat <= W;
  end

  // RK0 is applied on the accepting edge, before the latch holds the key.
  assign key_bus = (fsm == IDLE) ? W : w_lat;
`else
  assign key_bus = W;
`endif

  // IDLE applies the initial whitening key RK0.
  assign rsel = (fsm == IDLE) ? 4'd0 : rnd;

  // Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}: lowest-numbered word
  // lands in the top bits, i.e. word order is reversed against the bus.
  always_comb begin
    rk = '0;
    for (int r = 0; r <= Nr; r++) begin
      if (rsel == 4'(r)) begin
        rk = {key_bus[32*(4*r+1)-1 -: 32], key_bus[32*(4*r+2)-1 -: 32],
              key_bus[32*(4*r+3)-1 -: 32], key_bus[32*(4*r+4)-1 -: 32]};
      end
    end
  end

  // ---------------- Round function ----------------
  for (genvar i = 0; i < 16; i++) begin : g_sbox
    SubByte u_sub (
      .x (state[127-8*i -: 8]),
      .y (sb[127-8*i -: 8])
    );
  end

  // Byte i sits at row i%4, column i/4; row r rotates left by r columns.
  always_comb begin
    sr = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        sr[127-8*(4*c+r) -: 8] = sb[127-8*(4*((c+r)%4)+r) -: 8];
      end
    end
  end

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (8'h1b & {8{b[7]}});
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  always_comb begin
    mc = '0;
    for (int c = 0; c < 4; c++) begin
      mc[127-32*c -: 32] = mix_col(sr[127-32*c -: 32]);
    end
  end

  // The final round omits MixColumns.
  assign rnd_out = (last_rnd ? sr : mc) ^ rk;

  // ---------------- Datapath registers ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= '0;
      rnd   <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (in_valid) begin
            state <= plaintext ^ rk;
            rnd   <= 4'd1;
          end
        end
        ROUND: begin
          state <= rnd_out;
          // Hold at Nr so the counter never exceeds the round count.
          if (!last_rnd) rnd <= rnd + 4'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_aes_cipher_iter.sv
module tb_aes_cipher_iter;

  logic         clk;
  logic         reset;
  logic [2:0]   in_valid;
  logic [2:0]   in_ready;
  logic [2:0]   out_valid;
  logic [2:0]   out_ready;
  logic [2:0]   busy;
  logic [127:0] plaintext;
  logic [1919:0] wbus;
  logic [127:0] ct [3];

  int n_checks = 0;
  int n_err    = 0;

  logic [7:0] sbt [256];

  aes_cipher_iter #(.KeySize(128)) u128 (
    .clk(clk), .reset(reset), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .plaintext(plaintext), .W(wbus[1407:0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .ciphertext(ct[0]), .busy(busy[0]));

  aes_cipher_iter #(.KeySize(192)) u192 (
    .clk(clk), .reset(reset), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .plaintext(plaintext), .W(wbus[1663:0]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .ciphertext(ct[1]), .busy(busy[1]));

  aes_cipher_iter #(.KeySize(256)) u256 (
    .clk(clk), .reset(reset), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .plaintext(plaintext), .W(wbus), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .ciphertext(ct[2]), .busy(busy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- Reference model (byte-array AES) ----------------
  function automatic logic [7:0] gm(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from the field inverse plus the affine map, independent of any table.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++)
        if (gm(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] sub_word(input logic [31:0] t);
    return {sbt[t[31:24]], sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]]};
  endfunction

  // key is left-aligned: word i at key[255-32i -: 32].
  function automatic logic [1919:0] key_exp(input logic [255:0] key, input int nk);
    logic [31:0]   w [60];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1919:0] wb;
    int total;
    total = 4 * (nk + 7);
    rc = 8'h01;
    wb = '0;
    for (int i = 0; i < total; i++) begin
      if (i < nk) begin
        w[i] = key[255-32*i -: 32];
      end else begin
        t = w[i-1];
        if (i % nk == 0) begin
          t  = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gm(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = sub_word(t);
        end
        w[i] = w[i-nk] ^ t;
      end
      wb[32*i +: 32] = w[i];
    end
    return wb;
  endfunction

  function automatic logic [127:0] model_enc(input logic [127:0] pt,
                                             input logic [1919:0] wb, input int nr);
    logic [7:0]  s [16];
    logic [7:0]  t [16];
    logic [7:0]  a0, a1, a2, a3;
    logic [31:0] wd;
    logic [127:0] o;
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
    for (int r = 0; r <= nr; r++) begin
      if (r > 0) begin
        for (int i = 0; i < 16; i++) s[i] = sbt[s[i]];
        for (int c = 0; c < 4; c++)
          for (int rr = 0; rr < 4; rr++) t[rr+4*c] = s[rr+4*((c+rr)%4)];
        s = t;
        if (r != nr) begin
          for (int c = 0; c < 4; c++) begin
            a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
            s[4*c]   = gm(a0, 8'h02) ^ gm(a1, 8'h03) ^ a2 ^ a3;
            s[4*c+1] = a0 ^ gm(a1, 8'h02) ^ gm(a2, 8'h03) ^ a3;
            s[4*c+2] = a0 ^ a1 ^ gm(a2, 8'h02) ^ gm(a3, 8'h03);
            s[4*c+3] = gm(a0, 8'h03) ^ a1 ^ a2 ^ gm(a3, 8'h02);
          end
        end
      end
      for (int c = 0; c < 4; c++) begin
        wd = wb[32*(4*r+c) +: 32];
        for (int rr = 0; rr < 4; rr++) s[4*c+rr] = s[4*c+rr] ^ wd[31-8*rr -: 8];
      end
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  function automatic int nk_of(input int s);
    return (s == 0) ? 4 : (s == 1) ? 6 : 8;
  endfunction

  // ---------------- Checking helpers ----------------
  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_ne(input string tag, input logic [127:0] obs, input logic [127:0] bad);
    n_checks++;
    assert (obs !== bad) else begin
      n_err++;
      $error("FAIL %s observed=%h expected anything but %h", tag, obs, bad);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Offer a block; it is accepted on the next edge.
  task automatic send(input int s, input logic [127:0] pt, input string tag);
    chk({tag, "_in_ready"}, 128'(in_ready[s]), 128'd1);
    in_valid[s] = 1'b1;
    plaintext   = pt;
    step();
    in_valid[s] = 1'b0;
    chk({tag, "_busy"}, 128'(busy[s]), 128'd1);
  endtask

  // Counts edges from (and including) the accepting edge until out_valid.
  // A stray in_valid mid-block must be ignored.
  task automatic wait_out(input int s, input string tag);
    int edges;
    edges = 1;
    while (!out_valid[s] && edges < 64) begin
      if (edges == 2) begin
        in_valid[s] = 1'b1;
        plaintext   = {$urandom, $urandom, $urandom, $urandom};
      end
      step();
      in_valid[s] = 1'b0;
      edges++;
    end
    chk({tag, "_latency"}, 128'(edges), 128'(nk_of(s) + 7));
  endtask

  task automatic pop(input int s);
    out_ready[s] = 1'b1;
    step();
    out_ready[s] = 1'b0;
  endtask

  task automatic run_block(input int s, input logic [255:0] key, input logic [127:0] pt,
                           input logic [127:0] exp, input string tag);
    wbus = key_exp(key, nk_of(s));
    send(s, pt, tag);
    wait_out(s, tag);
    chk({tag, "_ct"}, ct[s], exp);
    pop(s);
    chk({tag, "_idle"}, 128'({in_ready[s], out_valid[s]}), 128'b10);
  endtask

  localparam logic [255:0] KEY128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] KEY192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
  localparam logic [255:0] KEY256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] PT1    = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CT1    = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] PT2    = 128'h00112233445566778899aabbccddeeff;

  initial begin
    logic [255:0] rkey;
    logic [127:0] rpt;
    logic [127:0] exp2;

    reset = 1'b1; in_valid = '0; out_ready = '0; plaintext = '0; wbus = '0;
    build_sbox();
    step(); step();
    chk("reset_outs", 128'({busy, out_valid}), 128'd0);
    chk("reset_ct", ct[0] | ct[1] | ct[2], 128'd0);
    reset = 1'b0;
    step();
    chk("reset_in_ready", 128'(in_ready), 128'b111);

    // Known-answer vectors for each key size.
    run_block(0, KEY128, PT1, CT1, "kat128");
    run_block(1, KEY192, PT2, 128'hdda97ca4864cdfe06eaf70a0ec0d7191, "kat192");
    run_block(2, KEY256, PT2, 128'h8ea2b7ca516745bfeafc49904b496089, "kat256");

    // Random keys and plaintexts against the model.
    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 3; n++) begin
        rkey = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        rpt  = {$urandom, $urandom, $urandom, $urandom};
        run_block(s, rkey, rpt, model_enc(rpt, key_exp(rkey, nk_of(s)), nk_of(s) + 6), "rand");
      end
    end

    // Backpressure: hold DONE for 20 cycles, then release and restart at once.
    wbus = key_exp(KEY128, 4);
    send(0, PT1, "bp");
    wait_out(0, "bp");
    for (int k = 0; k < 20; k++) begin
      step();
      chk("bp_hold_valid", 128'({out_valid[0], in_ready[0], busy[0]}), 128'b101);
      chk("bp_hold_ct", ct[0], CT1);
    end
    out_ready[0] = 1'b1;
    step();
    out_ready[0] = 1'b0;
    chk("bp_release", 128'({in_ready[0], out_valid[0], busy[0]}), 128'b100);
    rpt = {$urandom, $urandom, $urandom, $urandom};
    send(0, rpt, "bp2");
    wait_out(0, "bp2");
    chk("bp2_ct", ct[0], model_enc(rpt, key_exp(KEY128, 4), 10));
    pop(0);

    // Reset at rnd=5 with in_valid held high: reset wins, next edge accepts.
    send(0, PT1, "rst");
    for (int k = 0; k < 4; k++) step();
    exp2 = model_enc(PT2, key_exp(KEY128, 4), 10);
    reset = 1'b1;
    in_valid[0] = 1'b1;
    plaintext = PT2;
    step();
    chk("rst_abort", 128'({busy[0], out_valid[0], in_ready[0]}), 128'b001);
    chk("rst_ct", ct[0], 128'd0);
    reset = 1'b0;
    step();
    in_valid[0] = 1'b0;
    chk("rst_accept_busy", 128'(busy[0]), 128'd1);
    wait_out(0, "rst");
    chk("rst_new_ct", ct[0], exp2);
    pop(0);

    // Key bus zeroed right after acceptance.
    wbus = key_exp(KEY128, 4);
    send(0, PT1, "klat");
    wbus = '0;
    wait_out(0, "klat");
`ifdef AES_CIPHER_KEY_LATCH_EN
    chk("klat_ct", ct[0], CT1);
`else
    chk_ne("klat_ct_corrupt", ct[0], CT1);
`endif
    pop(0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
